// File: rtl/encoder_serializer.sv
// Priority encoder + serializer: captures an 8-bit request vector and
// emits the index of each set bit, lowest first, one per handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   d         request vector (bit i = request for index i)
//   load      capture d when in_ready=1
//   in_ready  high in IDLE (able to accept load)
//   idx       index of lowest set pending bit
//   valid     idx is meaningful (SCAN)
//   out_ready consumer accepts idx this cycle
//   zero      one-cycle pulse after a load of d=8'h00
//   cnt       popcount of pending (only with ENC_COUNT_EN)
//
// Optional feature macro: ENC_COUNT_EN adds the cnt port.

module encoder_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       load,
    output logic       in_ready,
    output logic [2:0] idx,
    output logic       valid,
    input  logic       out_ready,
    output logic       zero
`ifdef ENC_COUNT_EN
    ,
    output logic [3:0] cnt
`endif
);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic       r_zero;

    logic [2:0] w_idx;
    logic [7:0] w_lowbit;
    logic [7:0] w_next;

    // Lowest set bit wins: scan high to low so the last hit is the lowest.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Isolate the lowest set bit and drop it.
    assign w_lowbit = r_pending & (~r_pending + 8'd1);
    assign w_next   = r_pending & ~w_lowbit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 8'h00;
            r_zero    <= 1'b0;
        end else begin
            r_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        if (d != 8'h00) begin
                            r_pending <= d;
                            r_state   <= S_SCAN;
                        end else begin
                            r_zero <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    // Loads are ignored here; only the handshake advances.
                    if (out_ready) begin
                        r_pending <= w_next;
                        if (w_next == 8'h00) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign valid    = (r_state == S_SCAN);
    assign idx      = w_idx;
    assign zero     = r_zero;

`ifdef ENC_COUNT_EN
    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_cnt = w_cnt + {3'b000, r_pending[i]};
        end
    end

    assign cnt = w_cnt;
`endif

endmodule

// File: doc/encoder_serializer.md
ENCODER_SERIALIZER -- requirements
Module: encoder_serializer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 d  input  8  request vector, bit i = request for index i (inverse of 3-to-8 decode).
REQ-005 load  input  1  capture d when in_ready=1.
REQ-006 in_ready  output  1  high when IDLE and able to accept load.
REQ-007 idx  output  3  binary index of current lowest set pending bit.
REQ-008 valid  output  1  idx is meaningful.
REQ-009 out_ready  input  1  consumer accepts idx this cycle.
REQ-010 zero  output  1  one-cycle pulse: last accepted load carried d=8'h00.
REQ-011 cnt  output  4  pending-bit count, 0..8; present only with ENC_COUNT_EN.

Function
REQ-012 State machine SHALL have two states, IDLE and SCAN, plus an 8-bit pending register.
REQ-013 IDLE: in_ready=1, valid=0; load=1 with d!=0 -> pending<=d, next state SCAN.
REQ-014 IDLE: load=1 with d=0 -> stay IDLE, pending unchanged (0), zero=1 for exactly the next cycle.
REQ-015 SCAN: in_ready=0, valid=1, idx = position of lowest set bit of pending (bit 0 highest priority), combinational from pending.
REQ-016 Latency: load sampled at edge N -> valid=1 and first idx visible after edge N, before edge N+1.
REQ-017 Handshake: transfer occurs at a rising edge with valid=1 and out_ready=1; transferred bit SHALL be cleared from pending at that edge.
REQ-018 valid=1 with out_ready=0 SHALL hold idx and pending stable (no bit dropped, no reordering).
REQ-019 Transfer that clears the last pending bit -> next state IDLE; in_ready=1 the following cycle; no bubble cycle with valid=1 and pending=0.
REQ-020 load while in SCAN SHALL be ignored (pending, state unchanged); no error flag.
REQ-021 One index per transfer; d=8'hFF SHALL yield 8 transfers, idx 0,1,...,7.
REQ-022 No combinational path from out_ready to valid or idx.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, pending=8'h00, valid=0, in_ready=1, idx=3'd0, zero=0, cnt=0, independent of clk.
REQ-024 Reset mid-SCAN SHALL discard all untransferred bits; first edge after rst deasserts behaves as IDLE.

Configuration
REQ-025 Macro ENC_COUNT_EN defined: cnt port present, cnt = popcount(pending), updated in the same cycle as pending (8 after load 8'hFF, decrementing by 1 per transfer).
REQ-026 ENC_COUNT_EN undefined: cnt port and popcount logic absent; all other behaviour identical.

Verification
REQ-027 Reset then load=1, d=8'b1010_0100, out_ready=1 -> idx 2,5,7 on three consecutive cycles, valid=1 each, then valid=0, in_ready=1.
REQ-028 load d=8'h81, out_ready=0 for 4 cycles then 1 -> idx=0 held 4 cycles, then idx=7 one cycle, then IDLE.
REQ-029 load d=8'h00 -> zero=1 one cycle, valid stays 0, in_ready stays 1.
REQ-030 load d=8'hFF, second load d=8'h01 during SCAN -> exactly 8 transfers idx 0..7; second load ignored.
REQ-031 load d=8'h3C, rst pulsed asynchronously after first transfer -> valid=0 immediately, pending=0; new load d=8'h40 -> single idx=6.
REQ-032 With ENC_COUNT_EN: load d=8'hFF, out_ready=1 -> cnt 8,7,...,1, then 0 in IDLE.
